branch_predict_resolve: RTL

Parametrised successor to the execute-stage branch/jump unit: resolves B-type, JAL and JALR instructions, and maintains a direct-mapped branch target buffer (BTB) with saturating-counter direction prediction. Fetch queries the BTB combinationally each cycle. Execute presents resolved control-flow instructions. The block registers a one-cycle redirect on a mispredict and updates the table, giving the core dynamic prediction instead of a fixed not-taken policy.

---
 rtl/branch_predict_resolve.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/branch_predict_resolve.sv
// Execute-stage branch/jump resolution with a direct-mapped BTB and saturating-counter
// direction prediction; fetch looks up combinationally, execute resolves and trains.
module branch_predict_resolve #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CTR_BITS    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
    output logic                  lookup_taken_o,
    output logic [ADDR_WIDTH-1:0] lookup_target_o,
    input  logic                  valid_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] inst_i,
    input  logic [ADDR_WIDTH-1:0] inst_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic                  pred_taken_i,
    input  logic [ADDR_WIDTH-1:0] pred_addr_i,
    output logic                  redirect_o,
    output logic [ADDR_WIDTH-1:0] redirect_addr_o,
    output logic [31:0]           branch_cnt_o,
    output logic [31:0]           mispredict_cnt_o
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = ADDR_WIDTH - IW - 2;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
    localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(32'd1 << (CTR_BITS - 1));
    localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((32'd1 << (CTR_BITS - 1)) - 32'd1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(32'd4);

    logic                  valid_r  [BTB_ENTRIES];
    logic [TW-1:0]         tag_r    [BTB_ENTRIES];
    logic [ADDR_WIDTH-1:0] target_r [BTB_ENTRIES];
    logic [CTR_BITS-1:0]   ctr_r    [BTB_ENTRIES];

    logic                  redirect_r;
    logic [ADDR_WIDTH-1:0] redirect_addr_r;
    logic [31:0]           branch_cnt_r;
    logic [31:0]           mispredict_cnt_r;

    logic [IW-1:0]         lk_idx_s;
    logic                  lk_hit_s;
    logic [IW-1:0]         rs_idx_s;
    logic [TW-1:0]         rs_tag_s;
    logic                  rs_hit_s;
    logic [12:0]           bimm_raw_s;
    logic [ADDR_WIDTH-1:0] bimm_s;
    logic [ADDR_WIDTH-1:0] jr_sum_s;
    logic                  is_br_s;
    logic                  is_jmp_s;
    logic                  taken_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic                  cf_s;
    logic [ADDR_WIDTH-1:0] next_pc_s;
    logic                  mispred_s;
    logic                  wr_en_s;
    logic [ADDR_WIDTH-1:0] wr_target_s;
    logic [CTR_BITS-1:0]   wr_ctr_s;
    logic                  unused_s;

    assign unused_s   = ^inst_i[24:15];
    assign lk_idx_s   = lookup_addr_i[IW+1:2];
    assign rs_idx_s   = inst_addr_i[IW+1:2];
    assign rs_tag_s   = inst_addr_i[ADDR_WIDTH-1:IW+2];
    assign bimm_raw_s = {inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign bimm_s     = {{(ADDR_WIDTH-13){bimm_raw_s[12]}}, bimm_raw_s};
    assign jr_sum_s   = ADDR_WIDTH'(op1_i) + ADDR_WIDTH'(op2_i);

    // Fetch-side prediction straight from the table registers (no write bypass).
    always_comb begin
        lk_hit_s        = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lookup_addr_i[ADDR_WIDTH-1:IW+2]);
        lookup_taken_o  = lk_hit_s && ctr_r[lk_idx_s][CTR_BITS-1];
        if (lookup_taken_o) begin
            lookup_target_o = target_r[lk_idx_s];
        end else begin
            lookup_target_o = lookup_addr_i + PC_STEP;
        end
    end

    // Decode the execute-slot instruction and compute its real outcome.
    always_comb begin
        is_br_s  = 1'b0;
        is_jmp_s = 1'b0;
        taken_s  = 1'b0;
        target_s = inst_addr_i + bimm_s;
        case (inst_i[6:0])
            OP_BRANCH: begin
                case (inst_i[14:12])
                    3'b000: begin is_br_s = 1'b1; taken_s = (op1_i == op2_i); end
                    3'b001: begin is_br_s = 1'b1; taken_s = (op1_i != op2_i); end
                    3'b100: begin is_br_s = 1'b1; taken_s = ($signed(op1_i) <  $signed(op2_i)); end
                    3'b101: begin is_br_s = 1'b1; taken_s = ($signed(op1_i) >= $signed(op2_i)); end
                    3'b110: begin is_br_s = 1'b1; taken_s = (op1_i <  op2_i); end
                    3'b111: begin is_br_s = 1'b1; taken_s = (op1_i >= op2_i); end
                    default: begin is_br_s = 1'b0; taken_s = 1'b0; end
                endcase
            end
            OP_JAL: begin
                is_jmp_s = 1'b1;
                taken_s  = 1'b1;
                target_s = inst_addr_i + ADDR_WIDTH'(op2_i);
            end
            OP_JALR: begin
                is_jmp_s = 1'b1;
                taken_s  = 1'b1;
                target_s = {jr_sum_s[ADDR_WIDTH-1:1], 1'b0};
            end
            default: begin
                is_br_s  = 1'b0;
                is_jmp_s = 1'b0;
            end
        endcase
    end

    assign cf_s      = valid_i && !flush_i && (is_br_s || is_jmp_s);
    assign next_pc_s = taken_s ? target_s : (inst_addr_i + PC_STEP);
    assign mispred_s = (taken_s != pred_taken_i) || (taken_s && (target_s != pred_addr_i));

    // Table training: jumps force strongly taken, branches step the counter or allocate on taken miss.
    always_comb begin
        rs_hit_s    = valid_r[rs_idx_s] && (tag_r[rs_idx_s] == rs_tag_s);
        wr_en_s     = 1'b0;
        wr_target_s = target_r[rs_idx_s];
        wr_ctr_s    = ctr_r[rs_idx_s];
        if (!cf_s) begin
            wr_en_s = 1'b0;
        end else if (is_jmp_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = target_s;
            wr_ctr_s    = CTR_MAX;
        end else if (rs_hit_s) begin
            wr_en_s = 1'b1;
            if (taken_s) begin
                wr_target_s = target_s;
                if (ctr_r[rs_idx_s] != CTR_MAX) begin
                    wr_ctr_s = ctr_r[rs_idx_s] + CTR_BITS'(1);
                end else begin
                    wr_ctr_s = CTR_MAX;
                end
            end else begin
                if (ctr_r[rs_idx_s] != '0) begin
                    wr_ctr_s = ctr_r[rs_idx_s] - CTR_BITS'(1);
                end else begin
                    wr_ctr_s = '0;
                end
            end
        end else if (taken_s) begin
            wr_en_s     = 1'b1;
            wr_target_s = target_s;
            wr_ctr_s    = CTR_WT;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // BTB storage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= '0;
                ctr_r[i]    <= CTR_WNT;
            end
        end else if (wr_en_s) begin
            valid_r[rs_idx_s]  <= 1'b1;
            tag_r[rs_idx_s]    <= rs_tag_s;
            target_r[rs_idx_s] <= wr_target_s;
            ctr_r[rs_idx_s]    <= wr_ctr_s;
        end
    end

    // Redirect pulse and performance counters; redirect address holds between pulses.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            redirect_r       <= 1'b0;
            redirect_addr_r  <= '0;
            branch_cnt_r     <= 32'd0;
            mispredict_cnt_r <= 32'd0;
        end else begin
            redirect_r <= cf_s && mispred_s;
            if (cf_s && mispred_s) begin
                redirect_addr_r  <= next_pc_s;
                mispredict_cnt_r <= mispredict_cnt_r + 32'd1;
            end
            if (cf_s) begin
                branch_cnt_r <= branch_cnt_r + 32'd1;
            end
        end
    end

    assign redirect_o       = redirect_r;
    assign redirect_addr_o  = redirect_addr_r;
    assign branch_cnt_o     = branch_cnt_r;
    assign mispredict_cnt_o = mispredict_cnt_r;

endmodule
